asic_watch_cfg_tx: RTL and testbench

Wishbone-slave configuration transmitter for asic_watch. It accepts bus writes carrying a new time setting and checks the setting for range. It drives the watch's dvalid/cfg/smode inputs with a held valid pulse long enough for the 32.768 kHz watch logic to sample it. It also provides status/readback to firmware. It sits between the SoC Wishbone bus and asic_watch, in a single clock domain.

---
 rtl/asic_watch_pkg.sv | 33 +++
 rtl/asic_watch_cfg_check.sv | 17 +
 rtl/asic_watch_cfg_tx.sv | 179 +++++++++++++++++
 tb/tb_asic_watch_cfg_tx.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/asic_watch_pkg.sv
// Shared constants and types for the asic_watch configuration transmitter.
package asic_watch_pkg;

    // Word offsets of the two registers relative to the base address
    localparam int unsigned REG_CFG  = 0;
    localparam int unsigned REG_CTRL = 1;

    // Field layout of the configuration word
    localparam int unsigned HOURS_LSB = 0;
    localparam int unsigned HOURS_W   = 5;
    localparam int unsigned MIN_LSB   = 5;
    localparam int unsigned MIN_W     = 6;
    localparam int unsigned CFG_W     = 12;

    // Largest legal field values
    localparam int unsigned MAX_HOURS = 23;
    localparam int unsigned MAX_MIN   = 59;

    // Width of the hold counter; covers HOLD_CYCLES up to 255
    localparam int unsigned CNT_W = 8;

    typedef enum logic {
        IDLE,
        HOLD
    } cfg_tx_state_t;

    typedef struct packed {
        logic               rsvd;
        logic [MIN_W-1:0]   min;
        logic [HOURS_W-1:0] hr;
    } cfg_word_t;

endpackage

// File: rtl/asic_watch_cfg_check.sv
// Combinational range check of a time setting: hours 0..23, minutes 0..59.
module asic_watch_cfg_check
    import asic_watch_pkg::*;
(
    input  logic [HOURS_W-1:0] hr_i,
    input  logic [MIN_W-1:0]   min_i,
    output logic               valid_o
);

    logic hr_ok;
    logic min_ok;

    assign hr_ok   = (hr_i <= HOURS_W'(MAX_HOURS));
    assign min_ok  = (min_i <= MIN_W'(MAX_MIN));
    assign valid_o = hr_ok & min_ok;

endmodule

// File: rtl/asic_watch_cfg_tx.sv
// Wishbone slave that range-checks time settings and hands accepted ones to
// the watch core with a dvalid pulse held for HOLD_CYCLES clocks.
module asic_watch_cfg_tx
    import asic_watch_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic             sysclk_i,
    input  logic             rst_i,
    input  logic             wbs_cyc_i,
    input  logic             wbs_stb_i,
    input  logic             wbs_we_i,
    input  logic [3:0]       wbs_sel_i,
    input  logic [31:0]      wbs_adr_i,
    input  logic [31:0]      wbs_dat_i,
    output logic             wbs_ack_o,
    output logic [31:0]      wbs_dat_o,
    output logic             dvalid_o,
    output logic [CFG_W-1:0] cfg_o,
    output logic             smode_o
);

    localparam logic [29:0]      CfgWord  = BASE_ADDR[31:2] + 30'(REG_CFG);
    localparam logic [29:0]      CtrlWord = BASE_ADDR[31:2] + 30'(REG_CTRL);
    localparam logic [CNT_W-1:0] HoldInit = CNT_W'(HOLD_CYCLES - 1);

    // FSM and hold counter
    cfg_tx_state_t    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy;

    // Register file
    logic [CFG_W-1:0] cfg_q;
    logic             smode_q;
    logic             err_q;

    // Bus response
    logic             ack_q;
    logic [31:0]      rdata_q;
    logic [31:0]      rdata_d;

    // Request decode
    logic [29:0]      word_adr;
    logic             req;
    logic             hit_cfg;
    logic             hit_ctrl;
    logic             cfg_wr;
    logic             stall;
    logic             accept;
    logic             cfg_en;
    logic             range_ok;
    logic             cfg_ok;
    logic             cfg_bad;
    logic             ctrl_wr;
    cfg_word_t        wr_word;

    // Address low bits, upper selects and upper data bits have no function
    logic             unused_bits;
    assign unused_bits = ^{wbs_adr_i[1:0], wbs_sel_i[3:2], wbs_dat_i[31:11]};

    assign word_adr = wbs_adr_i[31:2];
    assign hit_cfg  = (word_adr == CfgWord);
    assign hit_ctrl = (word_adr == CtrlWord);

    // A new request is only recognised while no ack is being returned
    assign req      = wbs_cyc_i & wbs_stb_i & ~ack_q;
    assign cfg_wr   = req & wbs_we_i & hit_cfg;

    // CFG writes wait out an active hold; reads and CTRL writes never wait
    assign stall    = cfg_wr & (state_q == HOLD);
    assign accept   = req & ~stall;

    assign wr_word  = '{rsvd: 1'b0,
                        min:  wbs_dat_i[MIN_LSB +: MIN_W],
                        hr:   wbs_dat_i[HOURS_LSB +: HOURS_W]};

    asic_watch_cfg_check u_check (
        .hr_i    (wr_word.hr),
        .min_i   (wr_word.min),
        .valid_o (range_ok)
    );

    // Only a full low-halfword write updates the configuration
    assign cfg_en  = accept & cfg_wr & (wbs_sel_i[1:0] == 2'b11);
    assign cfg_ok  = cfg_en & range_ok;
    assign cfg_bad = cfg_en & ~range_ok;
    assign ctrl_wr = accept & wbs_we_i & hit_ctrl & wbs_sel_i[0];

    // State register and hold counter
    always_ff @(posedge sysclk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: enter HOLD on an accepted write, count down to exit
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (cfg_ok) begin
                    state_d = HOLD;
                    cnt_d   = HoldInit;
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
        endcase
    end

    // FSM outputs: dvalid is asserted for every cycle spent in HOLD
    always_comb begin
        dvalid_o = 1'b0;
        busy     = 1'b0;
        if (state_q == HOLD) begin
            dvalid_o = 1'b1;
            busy     = 1'b1;
        end
    end

    // Configuration, safe-mode and sticky error registers
    always_ff @(posedge sysclk_i) begin
        if (rst_i) begin
            cfg_q   <= '0;
            smode_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (cfg_ok) begin
                cfg_q <= wr_word;
            end
            if (cfg_bad) begin
                err_q <= 1'b1;
            end else if (ctrl_wr && wbs_dat_i[1]) begin
                err_q <= 1'b0;
            end
            if (ctrl_wr) begin
                smode_q <= wbs_dat_i[0];
            end
        end
    end

    // Read data mux; unmapped addresses read as zero
    always_comb begin
        rdata_d = '0;
        if (hit_cfg) begin
            rdata_d = {20'b0, cfg_q};
        end else if (hit_ctrl) begin
            rdata_d = {16'b0, cfg_q, 1'b0, busy, err_q, smode_q};
        end
    end

    // Registered ack and read data; data is zero outside a read ack
    always_ff @(posedge sysclk_i) begin
        if (rst_i) begin
            ack_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            ack_q   <= accept;
            rdata_q <= (accept && !wbs_we_i) ? rdata_d : '0;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = rdata_q;
    assign cfg_o     = cfg_q;
    assign smode_o   = smode_q;

endmodule

// File: tb/tb_asic_watch_cfg_tx.sv
`timescale 1ns/1ps
module tb_asic_watch_cfg_tx;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam int          H    = 4;
    localparam logic [29:0] W_CFG  = BASE[31:2];
    localparam logic [29:0] W_CTRL = BASE[31:2] + 30'd1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = 32'h0;
    logic [31:0] wdat = 32'h0;
    logic        ack;
    logic [31:0] rdat;
    logic        dvalid;
    logic [11:0] cfg;
    logic        smode;

    asic_watch_cfg_tx #(
        .BASE_ADDR   (BASE),
        .HOLD_CYCLES (H)
    ) dut (
        .sysclk_i  (clk),
        .rst_i     (rst),
        .wbs_cyc_i (cyc),
        .wbs_stb_i (stb),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_adr_i (adr),
        .wbs_dat_i (wdat),
        .wbs_ack_o (ack),
        .wbs_dat_o (rdat),
        .dvalid_o  (dvalid),
        .cfg_o     (cfg),
        .smode_o   (smode)
    );

    always #5 clk = ~clk;

    // Cycle index: after posedge k the value is k
    int cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    int checks = 0;
    int passes = 0;

    function void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc_n, act, exp);
    endfunction

    // Reference model: architectural state plus the cycle of the last accepted setting
    logic [10:0] m_cfg;
    logic        m_smode;
    logic        m_err;
    int          m_acc;

    typedef struct {
        logic        is_rd;
        logic [31:0] data;
        int          cyc;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    // The watch sees dvalid for H cycles starting at the acceptance cycle
    function logic busy_at(int c);
        return (c >= m_acc) && (c <= m_acc + H - 1);
    endfunction

    function logic [31:0] exp_read(logic [29:0] wa, int c);
        if (wa == W_CFG) return {21'b0, m_cfg};
        if (wa == W_CTRL) return {16'b0, 1'b0, m_cfg, 1'b0, busy_at(c), m_err, m_smode};
        return 32'h0;
    endfunction

    function void apply(logic w, logic [29:0] wa, logic [3:0] s, logic [31:0] d, int at);
        int hr;
        int mn;
        if (!w) return;
        hr = int'(d[4:0]);
        mn = int'(d[10:5]);
        if (wa == W_CFG && s[1:0] == 2'b11) begin
            if (hr < 24 && mn < 60) begin
                m_cfg = d[10:0];
                m_acc = at;
            end else begin
                m_err = 1'b1;
            end
        end else if (wa == W_CTRL && s[0]) begin
            m_smode = d[0];
            if (d[1]) m_err = 1'b0;
        end
    endfunction

    // Monitor: continuous output checks and scoreboard pop on every ack
    always @(negedge clk) begin
        if (!rst) begin
            chk("dvalid_o", dvalid, busy_at(cyc_n));
            chk("cfg_o", cfg, {1'b0, m_cfg});
            chk("smode_o", smode, m_smode);
            if (ack) begin
                chk("ack_expected", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    chk("ack_cycle", cyc_n, mon_e.cyc);
                    if (mon_e.is_rd) chk("read_data", rdat, mon_e.data);
                end
            end else begin
                chk("dat_idle_zero", rdat, 32'h0);
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        cyc = 1'b0;
        stb = 1'b0;
        we  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst     = 1'b0;
        m_cfg   = '0;
        m_smode = 1'b0;
        m_err   = 1'b0;
        m_acc   = -1000;
        sb.delete();
    endtask

    // One bus transaction; returns in the ack cycle with the bus released
    task automatic bus_op(input logic w, input logic [31:0] a, input logic [3:0] s,
                          input logic [31:0] d);
        int   e;
        int   a_exp;
        logic applied;
        exp_t it;
        logic [29:0] wa;
        wa = a[31:2];
        @(posedge clk);
        #1;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; wdat = d;
        e = cyc_n;
        a_exp = e + 1;
        if (w && wa == W_CFG && busy_at(e)) a_exp = m_acc + H + 1;
        it.is_rd = !w;
        it.data  = exp_read(wa, e);
        it.cyc   = a_exp;
        sb.push_back(it);
        applied = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (cyc_n == a_exp) begin
                apply(w, wa, s, d, a_exp);
                applied = 1'b1;
            end
            if (ack) break;
        end
        if (!applied) apply(w, wa, s, d, a_exp);
        chk("ack_seen", 32'(ack), 1);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    // CFG write presented during a hold and withdrawn before it can be accepted
    task automatic abandon_write(input logic [31:0] d);
        @(posedge clk);
        #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE; sel = 4'hF; wdat = d;
        @(posedge clk);
        #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    int          r;
    int          gap;
    logic        rw;
    logic [3:0]  rs;
    logic [31:0] ra;
    logic [31:0] rd;

    initial begin
        do_reset();
        chk("rst_ack", ack, 0);
        chk("rst_dat", rdat, 0);
        chk("rst_dvalid", dvalid, 0);
        chk("rst_cfg", cfg, 0);
        chk("rst_smode", smode, 0);
        bus_op(1'b0, BASE + 4, 4'hF, 0);

        // Valid setting, then readback once the hold has ended
        bus_op(1'b1, BASE, 4'hF, 32'h2F7);
        repeat (H + 1) @(posedge clk);
        bus_op(1'b0, BASE + 4, 4'hF, 0);
        bus_op(1'b0, BASE, 4'hF, 0);
        chk("cfg_held", cfg, 12'h2F7);

        // Out-of-range settings set the sticky error; CTRL bit1 clears it
        bus_op(1'b1, BASE, 4'hF, 32'h018);
        bus_op(1'b0, BASE + 4, 4'hF, 0);
        bus_op(1'b1, BASE, 4'hF, 32'(60 << 5));
        bus_op(1'b1, BASE + 4, 4'h1, 32'h2);
        bus_op(1'b0, BASE + 4, 4'hF, 0);

        // Back-to-back settings: second one waits for the first hold to end
        bus_op(1'b1, BASE, 4'hF, 32'h020);
        bus_op(1'b1, BASE, 4'hF, 32'h041);
        repeat (H + 1) @(posedge clk);
        chk("b2b_cfg", cfg, 12'h041);

        // Safe mode, unmapped accesses, partial byte select
        bus_op(1'b1, BASE + 4, 4'h1, 32'h1);
        bus_op(1'b1, BASE + 8, 4'hF, 32'hFFFF_FFFF);
        bus_op(1'b0, BASE + 8, 4'hF, 0);
        bus_op(1'b1, BASE, 4'b0001, 32'h00A);
        bus_op(1'b0, BASE + 4, 4'hF, 0);

        // Request withdrawn while stalled leaves everything untouched
        bus_op(1'b1, BASE, 4'hF, 32'h105);
        abandon_write(32'h0C3);
        repeat (H + 2) @(posedge clk);
        chk("abandon_cfg", cfg, 12'h105);

        // Reset in the second cycle of a hold
        bus_op(1'b1, BASE, 4'hF, 32'h2F7);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid_dvalid", dvalid, 0);
        chk("rst_mid_cfg", cfg, 0);
        do_reset();

        for (int i = 0; i < 10000; i++) begin
            r  = $urandom_range(0, 99);
            rw = 1'($urandom_range(0, 1));
            rs = ($urandom_range(0, 9) < 7) ? 4'hF : 4'($urandom_range(0, 15));
            if (r < 40)      ra = BASE | 32'($urandom_range(0, 3));
            else if (r < 75) ra = (BASE + 4) | 32'($urandom_range(0, 3));
            else if (r < 85) ra = BASE + 8;
            else             ra = $urandom();
            rd = $urandom();
            rd[4:0]  = 5'($urandom_range(0, 31));
            rd[10:5] = 6'($urandom_range(0, 63));
            bus_op(rw, ra, rs, rd);
            gap = $urandom_range(0, 1);
            repeat (gap) @(posedge clk);
        end

        repeat (H + 2) @(posedge clk);
        chk("sb_drained", 32'(sb.size()), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
